register_status_table: RTL and testbench
========================================

Name: register_status_table

Overview:
- Per-register pending-write scoreboard placed directly upstream of the hazard detector.
- On every issue slot it looks up both source registers and produces registered ass1_pending/ass1_row and ass2_pending/ass2_row, which drive the hazard detector's inputs.
- Entries are marked pending when an instruction issues with a destination register, and cleared when that producer's tag is broadcast on the writeback bus.
- The hazard detector's stalled output returns to this block and freezes both issue and lookup.

Parameters:
- NREGS, 32, number of architectural registers.
- ROW_W, 5, register index width; must equal log2(NREGS).
- TAG_W, 3, producer tag width.
- CNT_W, 6, width of the outstanding-write counter; must hold NREGS.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  instruction presented this cycle.
- issue_wr  in  1  instruction writes a destination register.
- issue_rd  in  ROW_W  destination register index.
- issue_tag  in  TAG_W  producer tag of the issuing instruction.
- issue_rs1  in  ROW_W  source register 1 index.
- issue_rs2  in  ROW_W  source register 2 index.
- stalled  in  1  stall from hazard detector.
- wb_valid  in  1  writeback broadcast valid.
- wb_tag  in  TAG_W  tag being written back.
- ass1_pending  out  1  source 1 has an outstanding write.
- ass1_row  out  ROW_W  source 1 index, registered.
- ass1_tag  out  TAG_W  producer tag for source 1; 0 when not pending.
- ass2_pending  out  1  source 2 has an outstanding write.
- ass2_row  out  ROW_W  source 2 index, registered.
- ass2_tag  out  TAG_W  producer tag for source 2; 0 when not pending.
- pending_count  out  CNT_W  number of registers currently pending.

Behaviour:
- Storage:
  - NREGS entries, each {pend bit, tag}.
  - Register 0 is never pending: writes to rd=0 are ignored and lookups of row 0 return pending=0.
- Reset (reset_n low, asynchronous):
  - All pend bits and tags clear.
  - All outputs go to 0: ass*_pending, ass*_row, ass*_tag, pending_count.
  - Reset asserted mid-operation discards all outstanding state; there is no recovery.
- Accepted issue: issue_valid=1 and stalled=0.
- Lookup, 1-cycle latency:
  - On an accepted issue, the next rising edge registers assN_row=issue_rsN, and assN_pending/assN_tag from the entry for issue_rsN.
  - When not accepted, all ass* outputs hold their values.
- Self-dependency: a lookup reads the table state from before this same instruction's own destination update. An instruction with rs1==rd does not see itself as pending.
- Set:
  - Applies on an accepted issue with issue_wr=1 and issue_rd!=0.
  - The entry for issue_rd gets pend=1 and tag=issue_tag.
  - A re-issue to an already-pending rd overwrites the tag (WAW: newest producer wins).
- Clear:
  - When wb_valid=1, every entry with pend=1 and tag==wb_tag clears pend and sets tag to 0.
  - Clearing is associative, and at most one entry normally matches.
- Simultaneous clear and set on the same entry in one cycle: the set wins, so the entry ends pending with the new tag.
- pending_count:
  - Equals the population count of the pend bits.
  - Updated incrementally: +1 on a set to a non-pending entry, −1 per cleared entry, net 0 when both happen on the same entry.
  - Saturates at NREGS and at 0.
  - Must always equal the popcount; the bench checks this.
- stalled:
  - Blocks both set and lookup.
  - Clears from wb still apply while stalled, but the registered ass* outputs do not refresh until the next accepted issue.
- Unknown wb_tag (no matching entry) has no effect.

Optional Feature:
- Macro: REGSTAT_WB_BYPASS_EN.
- Defined: a lookup whose source entry is cleared by wb in the same cycle reports pending=0 and tag=0. This is a combinational forward of the clear into the lookup.
- Undefined: the lookup uses pre-clear state and reports pending=1 with the old tag. The source appears pending one extra issue; the table entry itself still clears.

Test Plan:
1. Reset with reset_n=0 mid-run after 3 sets -> all outputs 0, pending_count=0; a following lookup of those rows returns pending=0.
2. Issue rd=5, tag=2, then issue rs1=5, rs2=1 -> ass1_pending=1, ass1_row=5'b00101, ass1_tag=2; ass2_pending=0; pending_count=1.
3. Issue rd=0, tag=4, then lookup rs1=0 -> pending=0 and pending_count unchanged.
4. Pending rd=7 with tag=3; same cycle wb_tag=3 and an issue with rd=7, tag=5 -> entry 7 pending with tag=5, pending_count unchanged.
5. Pending rd=9 with tag=1; issue rs1=9 while wb_tag=1 -> with REGSTAT_WB_BYPASS_EN, ass1_pending=0; without it, ass1_pending=1 and ass1_tag=1; in both cases pending_count decrements.
6. stalled=1 for 3 cycles while issue_rd=4 is presented -> entry 4 not set and ass* outputs held; on deassertion the issue is accepted and pending_count increments by 1.

Source files
------------

// File: rtl/register_status_table.sv
// Pending-write scoreboard: marks destination registers pending on issue, clears them on
// writeback tag match, and returns a registered lookup of both sources one cycle after issue.
// Define REGSTAT_WB_BYPASS_EN to forward same-cycle writeback clears into the lookup.
module register_status_table #(
    parameter int NREGS = 32,
    parameter int ROW_W = 5,
    parameter int TAG_W = 3,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic             issue_wr,
    input  logic [ROW_W-1:0] issue_rd,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [ROW_W-1:0] issue_rs1,
    input  logic [ROW_W-1:0] issue_rs2,
    input  logic             stalled,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    output logic             ass1_pending,
    output logic [ROW_W-1:0] ass1_row,
    output logic [TAG_W-1:0] ass1_tag,
    output logic             ass2_pending,
    output logic [ROW_W-1:0] ass2_row,
    output logic [TAG_W-1:0] ass2_tag,
    output logic [CNT_W-1:0] pending_count
);

    localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'(NREGS);

    logic [NREGS-1:0] pend_q, pend_d;
    logic [TAG_W-1:0] tag_q [NREGS];
    logic [TAG_W-1:0] tag_d [NREGS];

    logic             ass1_pending_q, ass1_pending_d;
    logic [ROW_W-1:0] ass1_row_q,     ass1_row_d;
    logic [TAG_W-1:0] ass1_tag_q,     ass1_tag_d;
    logic             ass2_pending_q, ass2_pending_d;
    logic [ROW_W-1:0] ass2_row_q,     ass2_row_d;
    logic [TAG_W-1:0] ass2_tag_q,     ass2_tag_d;
    logic [CNT_W-1:0] cnt_q,          cnt_d;

    logic             accept;
    logic             set_en;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] clr_eff;
    logic             inc;
    logic [CNT_W-1:0] nclr;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W:0]   cnt_diff;
    logic             src1_hit;
    logic             src2_hit;

    // Table update: a set on the same entry as a clear wins.
    always_comb begin
        accept = issue_valid & ~stalled;
        set_en = accept & issue_wr & (issue_rd != '0);
        set_vec = '0;
        clr_vec = '0;
        pend_d  = pend_q;
        for (int i = 0; i < NREGS; i++) begin
            set_vec[i] = set_en && (issue_rd == ROW_W'(i));
            clr_vec[i] = wb_valid && pend_q[i] && (tag_q[i] == wb_tag);
            tag_d[i]   = tag_q[i];
            if (set_vec[i]) begin
                pend_d[i] = 1'b1;
                tag_d[i]  = issue_tag;
            end else if (clr_vec[i]) begin
                pend_d[i] = 1'b0;
                tag_d[i]  = '0;
            end
        end
    end

    // Incremental count; a clear cancelled by a set on the same entry is not counted.
    always_comb begin
        clr_eff = clr_vec & ~set_vec;
        inc     = set_en & ~pend_q[issue_rd];
        nclr    = '0;
        for (int i = 0; i < NREGS; i++) begin
            nclr = nclr + CNT_W'(clr_eff[i]);
        end
        cnt_sum  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
        cnt_diff = cnt_sum - {1'b0, nclr};
        if (cnt_sum <= {1'b0, nclr}) begin
            cnt_d = '0;
        end else if (cnt_diff > CNT_MAX) begin
            cnt_d = CNT_MAX[CNT_W-1:0];
        end else begin
            cnt_d = cnt_diff[CNT_W-1:0];
        end
    end

    // Lookups read pre-update state, so an instruction never sees its own destination.
    always_comb begin
`ifdef REGSTAT_WB_BYPASS_EN
        src1_hit = (issue_rs1 != '0) && pend_q[issue_rs1] && !clr_vec[issue_rs1];
        src2_hit = (issue_rs2 != '0) && pend_q[issue_rs2] && !clr_vec[issue_rs2];
`else
        src1_hit = (issue_rs1 != '0) && pend_q[issue_rs1];
        src2_hit = (issue_rs2 != '0) && pend_q[issue_rs2];
`endif
        ass1_pending_d = ass1_pending_q;
        ass1_row_d     = ass1_row_q;
        ass1_tag_d     = ass1_tag_q;
        ass2_pending_d = ass2_pending_q;
        ass2_row_d     = ass2_row_q;
        ass2_tag_d     = ass2_tag_q;
        if (accept) begin
            ass1_pending_d = src1_hit;
            ass1_row_d     = issue_rs1;
            ass1_tag_d     = src1_hit ? tag_q[issue_rs1] : '0;
            ass2_pending_d = src2_hit;
            ass2_row_d     = issue_rs2;
            ass2_tag_d     = src2_hit ? tag_q[issue_rs2] : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q         <= '0;
            for (int i = 0; i < NREGS; i++) begin
                tag_q[i] <= '0;
            end
            ass1_pending_q <= 1'b0;
            ass1_row_q     <= '0;
            ass1_tag_q     <= '0;
            ass2_pending_q <= 1'b0;
            ass2_row_q     <= '0;
            ass2_tag_q     <= '0;
            cnt_q          <= '0;
        end else begin
            pend_q         <= pend_d;
            for (int i = 0; i < NREGS; i++) begin
                tag_q[i] <= tag_d[i];
            end
            ass1_pending_q <= ass1_pending_d;
            ass1_row_q     <= ass1_row_d;
            ass1_tag_q     <= ass1_tag_d;
            ass2_pending_q <= ass2_pending_d;
            ass2_row_q     <= ass2_row_d;
            ass2_tag_q     <= ass2_tag_d;
            cnt_q          <= cnt_d;
        end
    end

    assign ass1_pending  = ass1_pending_q;
    assign ass1_row      = ass1_row_q;
    assign ass1_tag      = ass1_tag_q;
    assign ass2_pending  = ass2_pending_q;
    assign ass2_row      = ass2_row_q;
    assign ass2_tag      = ass2_tag_q;
    assign pending_count = cnt_q;

endmodule

// File: tb/tb_register_status_table.sv
// Directed bench for register_status_table: vector table plus hand-written corner sequences.
module tb_register_status_table;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       issue_valid, issue_wr, stalled, wb_valid;
    logic [4:0] issue_rd, issue_rs1, issue_rs2;
    logic [2:0] issue_tag, wb_tag;
    logic       ass1_pending, ass2_pending;
    logic [4:0] ass1_row, ass2_row;
    logic [2:0] ass1_tag, ass2_tag;
    logic [5:0] pending_count;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        int v, wr, rd, tag, rs1, rs2, st, wbv, wbt;
        int p1, r1, t1, p2, r2, t2, cnt;
    } vec_t;

    vec_t vecs[$];

    register_status_table dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_tag(issue_tag), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .stalled(stalled), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .ass1_pending(ass1_pending), .ass1_row(ass1_row), .ass1_tag(ass1_tag),
        .ass2_pending(ass2_pending), .ass2_row(ass2_row), .ass2_tag(ass2_tag),
        .pending_count(pending_count)
    );

    always #5 clock = ~clock;

    task automatic add(input int v, wr, rd, tag, rs1, rs2, st, wbv, wbt,
                       input int p1, r1, t1, p2, r2, t2, cnt);
        vec_t x;
        x = '{v, wr, rd, tag, rs1, rs2, st, wbv, wbt, p1, r1, t1, p2, r2, t2, cnt};
        vecs.push_back(x);
    endtask

    task automatic drive(input int v, wr, rd, tag, rs1, rs2, st, wbv, wbt);
        issue_valid = 1'(v);
        issue_wr    = 1'(wr);
        issue_rd    = 5'(rd);
        issue_tag   = 3'(tag);
        issue_rs1   = 5'(rs1);
        issue_rs2   = 5'(rs2);
        stalled     = 1'(st);
        wb_valid    = 1'(wbv);
        wb_tag      = 3'(wbt);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int p1, r1, t1, p2, r2, t2, cnt);
        check({name, ".ass1_pending"}, int'(ass1_pending), p1);
        check({name, ".ass1_row"},     int'(ass1_row),     r1);
        check({name, ".ass1_tag"},     int'(ass1_tag),     t1);
        check({name, ".ass2_pending"}, int'(ass2_pending), p2);
        check({name, ".ass2_row"},     int'(ass2_row),     r2);
        check({name, ".ass2_tag"},     int'(ass2_tag),     t2);
        check({name, ".pending_count"}, int'(pending_count), cnt);
    endtask

    initial begin
        int exp_cnt;

        //   v wr rd tg rs1 rs2 st wbv wbt | p1 r1 t1 p2 r2 t2 cnt
        add(1, 1,  5, 2,  0,  0, 0, 0, 0,   0,  0, 0, 0,  0, 0, 1);
        add(1, 0,  0, 0,  5,  1, 0, 0, 0,   1,  5, 2, 0,  1, 0, 1);
        add(1, 1,  0, 4,  5,  5, 0, 0, 0,   1,  5, 2, 1,  5, 2, 1);
        add(1, 0,  0, 0,  0,  0, 0, 0, 0,   0,  0, 0, 0,  0, 0, 1);
        add(1, 1,  7, 3,  7,  5, 0, 0, 0,   0,  7, 0, 1,  5, 2, 2);
        add(1, 1,  7, 5,  1,  2, 0, 1, 3,   0,  1, 0, 0,  2, 0, 2);
        add(1, 0,  0, 0,  7,  5, 0, 0, 0,   1,  7, 5, 1,  5, 2, 2);
        add(0, 0,  0, 0,  3,  3, 0, 1, 2,   1,  7, 5, 1,  5, 2, 1);
        add(1, 0,  0, 0,  5,  7, 0, 0, 0,   0,  5, 0, 1,  7, 5, 1);
        add(1, 0,  0, 0,  7, 31, 0, 1, 6,   1,  7, 5, 0, 31, 0, 1);
        add(1, 1, 31, 1,  0,  0, 0, 0, 0,   0,  0, 0, 0,  0, 0, 2);
        add(1, 1, 31, 6, 31,  0, 0, 0, 0,   1, 31, 1, 0,  0, 0, 2);
        add(1, 0,  0, 0, 31,  7, 0, 1, 1,   1, 31, 6, 1,  7, 5, 2);
        add(0, 0,  0, 0,  0,  0, 0, 1, 6,   1, 31, 6, 1,  7, 5, 1);
        add(0, 0,  0, 0,  0,  0, 0, 1, 5,   1, 31, 6, 1,  7, 5, 0);
        add(1, 0,  0, 0, 31,  7, 0, 0, 0,   0, 31, 0, 0,  7, 0, 0);
        add(0, 0,  0, 0,  0,  0, 0, 1, 0,   0, 31, 0, 0,  7, 0, 0);

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].wr, vecs[i].rd, vecs[i].tag, vecs[i].rs1,
                  vecs[i].rs2, vecs[i].st, vecs[i].wbv, vecs[i].wbt);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].p1, vecs[i].r1, vecs[i].t1,
                      vecs[i].p2, vecs[i].r2, vecs[i].t2, vecs[i].cnt);
        end

        // Stall holds outputs and blocks the set until released.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 4, 7, 5, 6, 1, 0, 0);
            tick();
            check_all($sformatf("stall%0d", k), 0, 31, 0, 0, 7, 0, 0);
        end
        drive(1, 1, 4, 7, 5, 6, 0, 0, 0);
        tick();
        check_all("unstall", 0, 5, 0, 0, 6, 0, 1);

        // Lookup racing a writeback clear of the same source.
        drive(1, 1, 9, 1, 4, 0, 0, 0, 0);
        tick();
        check_all("set9", 1, 4, 7, 0, 0, 0, 2);
        drive(1, 0, 0, 0, 9, 4, 0, 1, 1);
        tick();
`ifdef REGSTAT_WB_BYPASS_EN
        check_all("wb_race", 0, 9, 0, 1, 4, 7, 1);
`else
        check_all("wb_race", 1, 9, 1, 1, 4, 7, 1);
`endif
        drive(1, 0, 0, 0, 9, 0, 0, 0, 0);
        tick();
        check_all("after_race", 0, 9, 0, 0, 0, 0, 1);

        // Fill every register, then drain several entries per writeback.
        for (int i = 1; i < 32; i++) begin
            drive(1, 1, i, i % 8, 0, 0, 0, 0, 0);
            tick();
            check($sformatf("fill%0d.pending_count", i), int'(pending_count), (i < 4) ? i + 1 : i);
        end
        for (int t = 0; t < 8; t++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, t);
            tick();
            exp_cnt = 0;
            for (int i = 1; i < 32; i++) if ((i % 8) > t) exp_cnt++;
            check($sformatf("drain%0d.pending_count", t), int'(pending_count), exp_cnt);
        end

        // Asynchronous reset mid-run discards outstanding entries.
        drive(1, 1, 10, 2, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 11, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 12, 4, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 10, 11, 0, 0, 0);
        tick();
        check_all("pre_reset", 1, 10, 2, 1, 11, 3, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        drive(1, 0, 0, 0, 10, 12, 0, 0, 0);
        tick();
        check_all("post_reset", 0, 10, 0, 0, 12, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
